demux3_router_out: RTL and testbench
====================================

# demux3_router_out

Registered 1-to-3 flit demultiplexer for the NoC router datapath, the dispatch counterpart to the 3-input output multiplexer. It accepts a flit stream on one input channel, latches a route from the head flit's `select`, and forwards every flit of that packet to one of three output channels through a one-entry register per channel with valid/ready handshaking. Packets with an invalid route (`select == 2'b11`) and stray non-head flits are consumed and counted as drops.

## Interface
- `DATA_PACKET_SIZE`, 10, flit width in bits
- `DROP_CNT_W`, 8, width of the saturating drop counter
- `clk`  in  1  system clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `data_in`  in  DATA_PACKET_SIZE  input flit
- `in_valid`  in  1  `data_in` valid
- `in_head`  in  1  flit is a packet head; `select` meaningful only with head
- `in_tail`  in  1  flit is the packet's last (head+tail = single-flit packet)
- `select`  in  2  route for the head flit: 00 → ch1, 01 → ch2, 10 → ch3, 11 → drop
- `in_ready`  out  1  input transfer occurs when `in_valid && in_ready`
- `out_data_1/2/3`  out  DATA_PACKET_SIZE each  output flit registers
- `out_valid_1/2/3`  out  1 each  output register holds a flit
- `out_ready_1/2/3`  in  1 each  downstream accepts; transfer on `out_valid_n && out_ready_n`
- `drop_pulse`  out  1  one-cycle pulse per dropped flit
- `drop_count`  out  DROP_CNT_W  saturating count of dropped flits

## Operation
- FSM states: IDLE, FORWARD, DROP. Register `route` (2 bits) holds the latched channel.
- Channel n can accept when `!out_valid_n || out_ready_n` (`can_load_n`).
- IDLE:
  - Head flit, `select` in 0..2: `in_ready = can_load[select]`. On transfer, load the flit into channel `select` and latch `route = select`. Go to FORWARD unless `in_tail`; a single-flit packet stays in IDLE.
  - Head flit, `select == 11`: `in_ready = 1`. The flit is dropped. Go to DROP unless `in_tail`.
  - Non-head flit (stray): `in_ready = 1`. The flit is dropped. Stay in IDLE.
- FORWARD: `in_ready = can_load[route]`. `in_head` and `select` are ignored. A flit transfer loads channel `route`. A transfer with `in_tail` returns the FSM to IDLE.
- DROP: `in_ready = 1`. Every flit is dropped. A flit with `in_tail` returns the FSM to IDLE.
- Output register n:
  - Loaded when the input transfer targets n; `out_valid_n` is set.
  - Otherwise cleared when `out_ready_n` is high.
  - A simultaneous drain and load keeps `out_valid_n = 1` with the new data.
- Each channel drains independently. A stalled channel never blocks the other channels' drains.
- Drop accounting: `drop_pulse` is registered, high for the cycle after each dropped transfer. `drop_count` increments on each drop and saturates at all-ones; it does not wrap.
- `in_ready` is combinational from state, `route`, `select`, `in_head` and the `out_valid`/`out_ready` inputs. No other output is combinational.

## Timing
- Reset values:
  - `out_valid_*` = 0, `out_data_*` = 0.
  - `drop_pulse` = 0, `drop_count` = 0.
  - FSM = IDLE, `route` = 00.
  - `in_ready` is forced to 0 while `reset` is high.
- Reset mid-packet: FSM returns to IDLE and buffered flits are discarded. After reset, remaining flits of the aborted packet arrive without a head and are dropped as strays.
- Latency: 1 cycle from an input transfer to `out_valid_n` high with that flit.
- Throughput: 1 flit/cycle sustained on a channel whose `out_ready` is held high.
- Backpressure: with `out_valid_n=1` and `out_ready_n=0`, `in_ready` is low while the packet targets n. The flit on `data_in` must be held by the source.
- Packet order within a channel is preserved. Packets are never interleaved on the input side.

## Test plan
- Single-flit routing: heads+tails 0x011/sel 00, 0x022/sel 01, 0x033/sel 10 on consecutive cycles, all `out_ready=1` → each appears one cycle later on ch1, ch2, ch3 respectively; `in_ready` stays 1; `drop_count`=0.
- Multi-flit packet: head sel 10 plus 3 body flits (last with tail), `select` toggled to 00 on the body flits → all 4 flits appear on ch3 in order; FSM back to IDLE after the tail.
- Backpressure: 4-flit packet to ch2 with `out_ready_2` held low for 3 cycles → `in_ready` drops after the first flit; no flit is lost or duplicated; drain resumes at 1 flit/cycle; ch1 and ch3 drain normally meanwhile.
- Drop path: 3-flit packet with sel 11, then a stray body flit in IDLE → 4 `drop_pulse` cycles, `drop_count`=4, no `out_valid` asserted. With `DROP_CNT_W`=8 and 300 drops, `drop_count` saturates at 255.
- Reset mid-packet: assert `reset` for 1 cycle after the 2nd flit of a 4-flit packet to ch1 → all outputs at reset values. The remaining 2 flits are dropped (`drop_count`=2), and the next head routes normally.

Source files
------------

// File: rtl/demux3_router_out_if.sv
// demux3_router_out_if
//   Bundles the flit input channel, the three output channels and the
//   drop-accounting outputs of the 1-to-3 router demultiplexer.
//
//   Input channel : data_in, in_valid, in_head, in_tail, select -> in_ready
//   Output n=1..3 : out_data_n, out_valid_n                     <- out_ready_n
//   Drop status   : drop_pulse, drop_count
//
//   modport master : flit source / downstream sinks (testbench side)
//   modport slave  : the demultiplexer itself
interface demux3_router_out_if #(
    parameter int DATA_PACKET_SIZE = 10,
    parameter int DROP_CNT_W       = 8
);
    logic [DATA_PACKET_SIZE-1:0] data_in;
    logic                        in_valid;
    logic                        in_head;
    logic                        in_tail;
    logic [1:0]                  select;
    logic                        in_ready;

    logic [DATA_PACKET_SIZE-1:0] out_data_1;
    logic [DATA_PACKET_SIZE-1:0] out_data_2;
    logic [DATA_PACKET_SIZE-1:0] out_data_3;
    logic                        out_valid_1;
    logic                        out_valid_2;
    logic                        out_valid_3;
    logic                        out_ready_1;
    logic                        out_ready_2;
    logic                        out_ready_3;

    logic                        drop_pulse;
    logic [DROP_CNT_W-1:0]       drop_count;

    modport master (
        output data_in, in_valid, in_head, in_tail, select,
        output out_ready_1, out_ready_2, out_ready_3,
        input  in_ready,
        input  out_data_1, out_data_2, out_data_3,
        input  out_valid_1, out_valid_2, out_valid_3,
        input  drop_pulse, drop_count
    );

    modport slave (
        input  data_in, in_valid, in_head, in_tail, select,
        input  out_ready_1, out_ready_2, out_ready_3,
        output in_ready,
        output out_data_1, out_data_2, out_data_3,
        output out_valid_1, out_valid_2, out_valid_3,
        output drop_pulse, drop_count
    );
endinterface

// File: rtl/demux3_router_out.sv
// demux3_router_out
//   Registered 1-to-3 flit demultiplexer. The head flit's select latches a
//   route; every flit of that packet is forwarded into a one-entry register
//   on the chosen output channel. Packets routed to 2'b11 and stray non-head
//   flits are consumed and counted as drops.
//
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : demux3_router_out_if.slave (input channel, three output
//           channels, drop_pulse / drop_count)
module demux3_router_out #(
    parameter int DATA_PACKET_SIZE = 10,
    parameter int DROP_CNT_W       = 8
) (
    input logic                clk,
    input logic                reset,
    demux3_router_out_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FORWARD = 2'd1,
        DROP    = 2'd2
    } state_t;

    localparam logic [1:0] DROP_SEL = 2'b11;

    state_t                      state, next_state;
    logic [1:0]                  route, next_route;

    logic [2:0]                  valid_q;
    logic [DATA_PACKET_SIZE-1:0] data_q [3];
    logic                        drop_pulse_q;
    logic [DROP_CNT_W-1:0]       drop_count_q;

    logic [2:0]                  out_ready_v;
    // Bit 3 stands for the drop route and can never accept a forwarded flit.
    logic [3:0]                  can_load;
    logic                        ready_c;
    logic                        xfer;
    logic [2:0]                  load;
    logic                        drop;

    assign out_ready_v = {bus.out_ready_3, bus.out_ready_2, bus.out_ready_1};
    assign can_load    = {1'b0, ~valid_q | out_ready_v};

    // in_ready is the only combinational output; it depends on the head's
    // select only while waiting for a new packet.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        ready_c = 1'b0;
        unique case (state)
            IDLE:    ready_c = (bus.in_head && bus.select != DROP_SEL)
                               ? can_load[bus.select] : 1'b1;
            FORWARD: ready_c = can_load[route];
            DROP:    ready_c = 1'b1;
            default: ready_c = 1'b0;
        endcase
        if (reset) begin
            ready_c = 1'b0;
        end
    end

    always_comb begin
        next_state = state;
        next_route = route;
        load       = 3'b000;
        drop       = 1'b0;
        xfer       = bus.in_valid && ready_c;
        unique case (state)
            IDLE: begin
                if (xfer) begin
                    if (bus.in_head && bus.select != DROP_SEL) begin
                        load       = 3'b001 << bus.select;
                        next_route = bus.select;
                        if (!bus.in_tail) next_state = FORWARD;
                    end else if (bus.in_head) begin
                        drop = 1'b1;
                        if (!bus.in_tail) next_state = DROP;
                    end else begin
                        // Stray body/tail flit with no open packet.
                        drop = 1'b1;
                    end
                end
            end
            FORWARD: begin
                if (xfer) begin
                    load = 3'b001 << route;
                    if (bus.in_tail) next_state = IDLE;
                end
            end
            DROP: begin
                if (xfer) begin
                    drop = 1'b1;
                    if (bus.in_tail) next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the flit registers are few and visible on ports, so they
            // are reset to a known value rather than left as don't-care.
            state        <= IDLE;
            route        <= 2'b00;
            valid_q      <= 3'b000;
            for (int n = 0; n < 3; n++) data_q[n] <= '0;
            drop_pulse_q <= 1'b0;
            drop_count_q <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            state <= next_state;
            route <= next_route;
            // A load wins over a drain, so a simultaneous drain and load
            // keeps the register valid with the new flit.
            for (int n = 0; n < 3; n++) begin
                if (load[n]) begin
                    valid_q[n] <= 1'b1;
                    data_q[n]  <= bus.data_in;
                end else if (out_ready_v[n]) begin
                    valid_q[n] <= 1'b0;
                end
            end
            drop_pulse_q <= drop;
            if (drop && drop_count_q != '1) begin
                drop_count_q <= drop_count_q + 1'b1;
            end
        end
    end

    assign bus.in_ready    = ready_c;
    assign bus.out_valid_1 = valid_q[0];
    assign bus.out_valid_2 = valid_q[1];
    assign bus.out_valid_3 = valid_q[2];
    assign bus.out_data_1  = data_q[0];
    assign bus.out_data_2  = data_q[1];
    assign bus.out_data_3  = data_q[2];
    assign bus.drop_pulse  = drop_pulse_q;
    assign bus.drop_count  = drop_count_q;

endmodule

// File: tb/tb_demux3_router_out.sv
// tb_demux3_router_out
//   Directed, self-checking bench for demux3_router_out. Inputs change 1 ns
//   after the rising edge; in_ready is sampled 1 ns after that, registered
//   outputs are sampled 1 ns after the edge that updates them.
module tb_demux3_router_out;

    localparam int W  = 10;
    localparam int CW = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    demux3_router_out_if #(.DATA_PACKET_SIZE(W), .DROP_CNT_W(CW)) bus ();

    demux3_router_out #(.DATA_PACKET_SIZE(W), .DROP_CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic h, input logic t,
                         input logic [1:0] sel, input logic [W-1:0] d);
        bus.in_valid = v;
        bus.in_head  = h;
        bus.in_tail  = t;
        bus.select   = sel;
        bus.data_in  = d;
    endtask

    task automatic set_ready(input logic r1, input logic r2, input logic r3);
        bus.out_ready_1 = r1;
        bus.out_ready_2 = r2;
        bus.out_ready_3 = r3;
    endtask

    task automatic test_reset();
        set_ready(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 2'b00, 10'h3FF);
        #1;
        if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end total++;
        cyc();
        cyc();
        if ({bus.out_valid_3, bus.out_valid_2, bus.out_valid_1} !== 3'b000) begin bad++; $display("FAIL reset_valid got=%b exp=000", {bus.out_valid_3, bus.out_valid_2, bus.out_valid_1}); end total++;
        if (bus.out_data_1 !== 10'h000) begin bad++; $display("FAIL reset_data1 got=%h exp=000", bus.out_data_1); end total++;
        if (bus.drop_count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.drop_count); end total++;
        if (bus.drop_pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse got=%b exp=0", bus.drop_pulse); end total++;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 10'h000);
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_single_flit();
        set_ready(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 2'b00, 10'h011);
        #1;
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL single_rdy1 got=%b exp=1", bus.in_ready); end total++;
        cyc();
        if (bus.out_valid_1 !== 1'b1 || bus.out_data_1 !== 10'h011) begin bad++; $display("FAIL single_ch1 got=%b/%h exp=1/011", bus.out_valid_1, bus.out_data_1); end total++;
        drive(1'b1, 1'b1, 1'b1, 2'b01, 10'h022);
        #1;
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL single_rdy2 got=%b exp=1", bus.in_ready); end total++;
        cyc();
        if (bus.out_valid_2 !== 1'b1 || bus.out_data_2 !== 10'h022) begin bad++; $display("FAIL single_ch2 got=%b/%h exp=1/022", bus.out_valid_2, bus.out_data_2); end total++;
        if (bus.out_valid_1 !== 1'b0) begin bad++; $display("FAIL single_ch1_drained got=%b exp=0", bus.out_valid_1); end total++;
        drive(1'b1, 1'b1, 1'b1, 2'b10, 10'h033);
        #1;
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL single_rdy3 got=%b exp=1", bus.in_ready); end total++;
        cyc();
        if (bus.out_valid_3 !== 1'b1 || bus.out_data_3 !== 10'h033) begin bad++; $display("FAIL single_ch3 got=%b/%h exp=1/033", bus.out_valid_3, bus.out_data_3); end total++;
        if (bus.out_valid_2 !== 1'b0) begin bad++; $display("FAIL single_ch2_drained got=%b exp=0", bus.out_valid_2); end total++;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 10'h000);
        cyc();
        if (bus.drop_count !== 8'd0) begin bad++; $display("FAIL single_count got=%0d exp=0", bus.drop_count); end total++;
        if (bus.out_valid_3 !== 1'b0) begin bad++; $display("FAIL single_ch3_drained got=%b exp=0", bus.out_valid_3); end total++;
    endtask

    task automatic test_multi_flit();
        logic [W-1:0] exp_d [4];
        exp_d[0] = 10'h100; exp_d[1] = 10'h101; exp_d[2] = 10'h102; exp_d[3] = 10'h103;
        set_ready(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 2'b10, exp_d[0]);
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (bus.out_valid_3 !== 1'b1 || bus.out_data_3 !== exp_d[i]) begin bad++; $display("FAIL multi_flit%0d got=%b/%h exp=1/%h", i, bus.out_valid_3, bus.out_data_3, exp_d[i]); end total++;
            if (bus.out_valid_1 !== 1'b0) begin bad++; $display("FAIL multi_ch1_idle%0d got=%b exp=0", i, bus.out_valid_1); end total++;
            if (i < 3) drive(1'b1, 1'b0, (i == 2), 2'b00, exp_d[i+1]);
        end
        // FSM must be back in IDLE: a fresh single-flit head to ch1 routes there.
        drive(1'b1, 1'b1, 1'b1, 2'b00, 10'h104);
        cyc();
        if (bus.out_valid_1 !== 1'b1 || bus.out_data_1 !== 10'h104) begin bad++; $display("FAIL multi_idle_after_tail got=%b/%h exp=1/104", bus.out_valid_1, bus.out_data_1); end total++;
        if (bus.out_valid_3 !== 1'b0) begin bad++; $display("FAIL multi_ch3_drained got=%b exp=0", bus.out_valid_3); end total++;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 10'h000);
        cyc();
    endtask

    task automatic test_backpressure();
        // Park single flits in ch1 and ch3 so their drains overlap the ch2 stall.
        set_ready(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 2'b00, 10'h0A1);
        cyc();
        drive(1'b1, 1'b1, 1'b1, 2'b10, 10'h0A3);
        cyc();
        if (bus.out_valid_1 !== 1'b1 || bus.out_valid_3 !== 1'b1) begin bad++; $display("FAIL bp_parked got=%b%b exp=11", bus.out_valid_1, bus.out_valid_3); end total++;
        set_ready(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 2'b01, 10'h200);
        #1;
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_head_ready got=%b exp=1", bus.in_ready); end total++;
        cyc();
        if (bus.out_valid_2 !== 1'b1 || bus.out_data_2 !== 10'h200) begin bad++; $display("FAIL bp_ch2_head got=%b/%h exp=1/200", bus.out_valid_2, bus.out_data_2); end total++;
        if (bus.out_valid_1 !== 1'b0 || bus.out_valid_3 !== 1'b0) begin bad++; $display("FAIL bp_side_drain got=%b%b exp=00", bus.out_valid_1, bus.out_valid_3); end total++;
        drive(1'b1, 1'b0, 1'b0, 2'b00, 10'h201);
        for (int s = 0; s < 2; s++) begin
            #1;
            if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_stall_ready%0d got=%b exp=0", s, bus.in_ready); end total++;
            cyc();
            if (bus.out_valid_2 !== 1'b1 || bus.out_data_2 !== 10'h200) begin bad++; $display("FAIL bp_stall_hold%0d got=%b/%h exp=1/200", s, bus.out_valid_2, bus.out_data_2); end total++;
        end
        bus.out_ready_2 = 1'b1;
        #1;
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_resume_ready got=%b exp=1", bus.in_ready); end total++;
        cyc();
        if (bus.out_valid_2 !== 1'b1 || bus.out_data_2 !== 10'h201) begin bad++; $display("FAIL bp_flit1 got=%b/%h exp=1/201", bus.out_valid_2, bus.out_data_2); end total++;
        drive(1'b1, 1'b0, 1'b0, 2'b00, 10'h202);
        cyc();
        if (bus.out_valid_2 !== 1'b1 || bus.out_data_2 !== 10'h202) begin bad++; $display("FAIL bp_flit2 got=%b/%h exp=1/202", bus.out_valid_2, bus.out_data_2); end total++;
        drive(1'b1, 1'b0, 1'b1, 2'b00, 10'h203);
        cyc();
        if (bus.out_valid_2 !== 1'b1 || bus.out_data_2 !== 10'h203) begin bad++; $display("FAIL bp_flit3 got=%b/%h exp=1/203", bus.out_valid_2, bus.out_data_2); end total++;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 10'h000);
        cyc();
        if (bus.out_valid_2 !== 1'b0) begin bad++; $display("FAIL bp_final_drain got=%b exp=0", bus.out_valid_2); end total++;
        if (bus.drop_count !== 8'd0) begin bad++; $display("FAIL bp_count got=%0d exp=0", bus.drop_count); end total++;
    endtask

    task automatic test_drop();
        set_ready(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 2'b11, 10'h300);
        #1;
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL drop_head_ready got=%b exp=1", bus.in_ready); end total++;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            if (bus.drop_pulse !== 1'b1) begin bad++; $display("FAIL drop_pulse%0d got=%b exp=1", i, bus.drop_pulse); end total++;
            if (bus.drop_count !== 8'(i)) begin bad++; $display("FAIL drop_count%0d got=%0d exp=%0d", i, bus.drop_count, i); end total++;
            if ({bus.out_valid_3, bus.out_valid_2, bus.out_valid_1} !== 3'b000) begin bad++; $display("FAIL drop_no_valid%0d got=%b exp=000", i, {bus.out_valid_3, bus.out_valid_2, bus.out_valid_1}); end total++;
            // flits 2,3 finish the dropped packet; flit 4 is a stray in IDLE
            if (i < 4) drive(1'b1, 1'b0, (i == 2), 2'b00, 10'(10'h300 + i));
        end
        drive(1'b0, 1'b0, 1'b0, 2'b00, 10'h000);
        cyc();
        if (bus.drop_pulse !== 1'b0 || bus.drop_count !== 8'd4) begin bad++; $display("FAIL drop_settle got=%b/%0d exp=0/4", bus.drop_pulse, bus.drop_count); end total++;
    endtask

    task automatic test_reset_mid_packet();
        set_ready(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 2'b00, 10'h400);
        cyc();
        drive(1'b1, 1'b0, 1'b0, 2'b00, 10'h401);
        cyc();
        if (bus.out_valid_1 !== 1'b1 || bus.out_data_1 !== 10'h401) begin bad++; $display("FAIL rmid_pre got=%b/%h exp=1/401", bus.out_valid_1, bus.out_data_1); end total++;
        bus.out_ready_1 = 1'b0;
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 2'b00, 10'h402);
        #1;
        if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rmid_ready_in_reset got=%b exp=0", bus.in_ready); end total++;
        cyc();
        if (bus.out_valid_1 !== 1'b0 || bus.out_data_1 !== 10'h000) begin bad++; $display("FAIL rmid_outputs got=%b/%h exp=0/000", bus.out_valid_1, bus.out_data_1); end total++;
        if (bus.drop_count !== 8'd0 || bus.drop_pulse !== 1'b0) begin bad++; $display("FAIL rmid_drop_reset got=%0d/%b exp=0/0", bus.drop_count, bus.drop_pulse); end total++;
        reset = 1'b0;
        bus.out_ready_1 = 1'b1;
        cyc();
        if (bus.drop_pulse !== 1'b1 || bus.drop_count !== 8'd1) begin bad++; $display("FAIL rmid_stray1 got=%b/%0d exp=1/1", bus.drop_pulse, bus.drop_count); end total++;
        drive(1'b1, 1'b0, 1'b1, 2'b00, 10'h403);
        cyc();
        if (bus.drop_count !== 8'd2 || bus.out_valid_1 !== 1'b0) begin bad++; $display("FAIL rmid_stray2 got=%0d/%b exp=2/0", bus.drop_count, bus.out_valid_1); end total++;
        drive(1'b1, 1'b1, 1'b1, 2'b00, 10'h404);
        cyc();
        if (bus.out_valid_1 !== 1'b1 || bus.out_data_1 !== 10'h404) begin bad++; $display("FAIL rmid_next_head got=%b/%h exp=1/404", bus.out_valid_1, bus.out_data_1); end total++;
        if (bus.drop_count !== 8'd2 || bus.drop_pulse !== 1'b0) begin bad++; $display("FAIL rmid_final_drop got=%0d/%b exp=2/0", bus.drop_count, bus.drop_pulse); end total++;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 10'h000);
        cyc();
    endtask

    task automatic test_saturation();
        int exp_cnt;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 2'b00, 10'h055);
        for (int i = 1; i <= 300; i++) begin
            cyc();
            exp_cnt = (i < 255) ? i : 255;
            if (i == 254 || i == 255 || i == 256 || i == 300) begin
                if (bus.drop_count !== 8'(exp_cnt)) begin bad++; $display("FAIL sat_count_after%0d got=%0d exp=%0d", i, bus.drop_count, exp_cnt); end total++;
            end
        end
        if (bus.drop_pulse !== 1'b1) begin bad++; $display("FAIL sat_pulse got=%b exp=1", bus.drop_pulse); end total++;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 10'h000);
        cyc();
        if (bus.drop_pulse !== 1'b0 || bus.drop_count !== 8'd255) begin bad++; $display("FAIL sat_hold got=%b/%0d exp=0/255", bus.drop_pulse, bus.drop_count); end total++;
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 2'b00, 10'h000);
        set_ready(1'b1, 1'b1, 1'b1);
        #1;
        test_reset();
        test_single_flit();
        test_multi_flit();
        test_backpressure();
        test_drop();
        test_reset_mid_packet();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
